// File: rtl/encode_align_multi.sv
// Multi-channel encoder align stage: one encoder stream feeds a ring buffer and
// every channel emits its own delayed (negative set) or late-started (positive set) copy.
module encode_align_multi #(
   parameter int ENCODE_WIDTH = 32,
   parameter int CH_NUM       = 4,
   parameter int DEPTH_LOG2   = 12
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           encode_sim_en_i,
   input  logic [ENCODE_WIDTH-1:0]        encode_sim_i,
   input  logic                           precise_encode_en_i,
   input  logic [ENCODE_WIDTH-1:0]        precise_encode_i,
   input  logic                           scan_en_i,
   input  logic                           align_rst_i,
   input  logic [CH_NUM*32-1:0]           align_set_i,
   output logic [CH_NUM-1:0]              encode_en_o,
   output logic [CH_NUM*ENCODE_WIDTH-1:0] encode_o,
   output logic                           align_ready_o,
   output logic [CH_NUM-1:0]              sat_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] MAX_N = '1;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_PASS} ch_state_e;

   logic                    flush;
   logic                    scan_q;
   logic                    scan_rise;
   logic [ENCODE_WIDTH-1:0] smp;
   logic                    smp_v;
   logic [DEPTH_LOG2-1:0]   wr_ptr;
   logic [DEPTH_LOG2-1:0]   hist_cnt;
   logic [DEPTH_LOG2-1:0]   max_n;
   logic                    ready_q;
   logic [ENCODE_WIDTH-1:0] mem [DEPTH];

   ch_state_e               state_q [CH_NUM];
   ch_state_e               state_d [CH_NUM];
   logic [15:0]             cnt_q   [CH_NUM];
   logic [15:0]             m_q     [CH_NUM];
   logic [DEPTH_LOG2-1:0]   n_q     [CH_NUM];
   logic                    neg_q   [CH_NUM];
   logic [ENCODE_WIDTH-1:0] dout_q  [CH_NUM];
   logic [CH_NUM-1:0]       en_q;
   logic [CH_NUM-1:0]       sat_q;
   logic [CH_NUM-1:0]       emit;

   logic [DEPTH_LOG2-1:0]   set_n   [CH_NUM];
   logic [15:0]             set_m   [CH_NUM];
   logic                    set_neg [CH_NUM];
   logic                    set_pos [CH_NUM];
   logic                    set_sat [CH_NUM];

   assign flush     = rst_i | align_rst_i;
   assign scan_rise = scan_en_i & ~scan_q;

   // Decode each channel's set into a clamped delay N or start offset M.
   always_comb begin
      logic [31:0] set_w;
      logic [31:0] mag;
      for (int k = 0; k < CH_NUM; k++) begin
         set_w      = align_set_i[32*k +: 32];
         mag        = ~set_w + 32'd1;
         set_neg[k] = set_w[31];
         set_pos[k] = ~set_w[31] & (|set_w);
         set_n[k]   = '0;
         set_m[k]   = '0;
         set_sat[k] = 1'b0;
         if (set_neg[k]) begin
            if (mag > 32'(MAX_N)) begin
               set_n[k]   = MAX_N;
               set_sat[k] = 1'b1;
            end else begin
               set_n[k] = mag[DEPTH_LOG2-1:0];
            end
         end else if (set_pos[k]) begin
            if (|set_w[30:16]) begin
               set_m[k]   = 16'hFFFF;
               set_sat[k] = 1'b1;
            end else begin
               set_m[k] = set_w[15:0];
            end
         end
      end
   end

   always_comb begin
      max_n = '0;
      for (int k = 0; k < CH_NUM; k++) begin
         if (neg_q[k] && n_q[k] > max_n) max_n = n_q[k];
      end
   end

   always_comb begin
      for (int k = 0; k < CH_NUM; k++) begin
         state_d[k] = state_q[k];
         emit[k]    = smp_v && (state_q[k] == ST_PASS) && (!neg_q[k] || hist_cnt >= n_q[k]);
         case (state_q[k])
            ST_IDLE: if (scan_rise) state_d[k] = set_pos[k] ? ST_WAIT : ST_PASS;
            ST_WAIT: begin
               if (!scan_en_i)                         state_d[k] = ST_IDLE;
               else if (cnt_q[k] == m_q[k] - 16'd1)    state_d[k] = ST_PASS;
            end
            ST_PASS: if (!scan_en_i) state_d[k] = ST_IDLE;
            default: state_d[k] = ST_IDLE;
         endcase
      end
   end

   // Not reset, so a scan held high through reset never looks like a fresh rise.
   always_ff @(posedge clk_i) scan_q <= scan_en_i;

   always_ff @(posedge clk_i) begin
      if (smp_v && !flush) mem[wr_ptr] <= smp;
   end

   always_ff @(posedge clk_i) begin
      if (flush) begin
         smp      <= '0;
         smp_v    <= 1'b0;
         wr_ptr   <= '0;
         hist_cnt <= '0;
         ready_q  <= 1'b0;
         en_q     <= '0;
         sat_q    <= '0;
         for (int k = 0; k < CH_NUM; k++) begin
            state_q[k] <= ST_IDLE;
            cnt_q[k]   <= '0;
            m_q[k]     <= '0;
            n_q[k]     <= '0;
            neg_q[k]   <= 1'b0;
            dout_q[k]  <= '0;
         end
      end else begin
         smp   <= encode_sim_en_i ? encode_sim_i : precise_encode_i;
         smp_v <= encode_sim_en_i | precise_encode_en_i;
         if (smp_v) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (hist_cnt != MAX_N) hist_cnt <= hist_cnt + 1'b1;
         end
         ready_q <= (hist_cnt >= max_n);
         for (int k = 0; k < CH_NUM; k++) begin
            state_q[k] <= state_d[k];
            cnt_q[k]   <= (state_q[k] == ST_WAIT) ? cnt_q[k] + 16'd1 : 16'd0;
            if (scan_rise) begin
               n_q[k]   <= set_n[k];
               m_q[k]   <= set_m[k];
               neg_q[k] <= set_neg[k];
               if (set_sat[k]) sat_q[k] <= 1'b1;
            end
            en_q[k] <= emit[k];
            // The RAM read and the pass-through share this register, so both paths see equal latency.
            if (emit[k]) dout_q[k] <= (neg_q[k] && n_q[k] != '0) ? mem[wr_ptr - n_q[k]] : smp;
         end
      end
   end

   always_comb begin
      encode_o = '0;
      for (int k = 0; k < CH_NUM; k++) encode_o[k*ENCODE_WIDTH +: ENCODE_WIDTH] = dout_q[k];
   end

   assign encode_en_o   = en_q;
   assign sat_o         = sat_q;
   assign align_ready_o = ready_q;

endmodule
